bus_xfer_ctrl: RTL and testbench
================================

BUS_XFER_CTRL -- requirements
Module: bus_xfer_ctrl

Interface
REQ-001 Parameter: N_REG, default 8, number of bus-attached registers; legal values 2..16.
REQ-002 Parameter: ID_W, default 3, register-ID width, equal to ceil(log2(N_REG)).
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, synchronous and active-high, sampled on posedge clk.
REQ-005 req_valid  input  1  transfer request present.
REQ-006 req_ready  output  1  request FIFO can accept.
REQ-007 req_src  input  ID_W  register that drives the bus.
REQ-008 req_dst  input  ID_W  register that latches from the bus.
REQ-009 reg_out  output  N_REG  one-hot bus-drive strobes (the *_out enables).
REQ-010 reg_in  output  N_REG  one-hot latch strobes (the *_in enables).
REQ-011 busy  output  1  FSM not in IDLE, or FIFO not empty.
REQ-012 done  output  1  one-cycle pulse on completion of a transfer.
REQ-013 err  output  1  one-cycle pulse when a request is rejected.
REQ-014 xfer_cnt  output  16  count of completed transfers.

Function
REQ-015 Handshake: a request is accepted on a posedge where req_valid && req_ready.
REQ-016 Request FIFO: 2 entries; req_ready = !full.
REQ-017 Simultaneous push and pop on a full FIFO: the push SHALL be accepted.
REQ-018 Validation on accept: a request with src==dst, src>=N_REG or dst>=N_REG SHALL NOT be enqueued; err pulses in the next cycle.
REQ-019 FSM states: IDLE, DRIVE, LATCH, DONE.
REQ-020 IDLE->DRIVE when the FIFO is non-empty; the head entry is popped on that edge.
REQ-021 DRIVE lasts 1 cycle: reg_out[src]=1, reg_in=0 (bus settle).
REQ-022 LATCH lasts 1 cycle: reg_out[src]=1, reg_in[dst]=1; the target captures on the negedge within this cycle.
REQ-023 DONE lasts 1 cycle: strobes 0; done=1; xfer_cnt increments.
REQ-024 DONE->DRIVE directly if the FIFO is non-empty, otherwise DONE->IDLE.
REQ-025 Latency into an empty, idle block: accept at edge k, DRIVE in cycle k+1, LATCH in k+2, done in k+3; back-to-back throughput is one transfer per 3 cycles.
REQ-026 Invariants: at most one bit of reg_out set; at most one bit of reg_in set; never reg_in[i] && reg_out[i].
REQ-027 All outputs SHALL be registered (glitch-free strobes).
REQ-028 xfer_cnt saturates at 16'hFFFF.

Reset
REQ-029 On rst: FSM IDLE, FIFO empty, reg_out=0, reg_in=0, done=0, err=0, busy=0, xfer_cnt=0, req_ready=1.
REQ-030 Reset mid-transfer SHALL abort the transfer in the same edge with no done pulse; queued requests are discarded.
REQ-031 Requests presented while rst=1 SHALL be ignored.

Configuration
REQ-032 Macro BUS_XFER_COUNT_EN: when defined, xfer_cnt operates per REQ-023/REQ-028.
REQ-033 Without BUS_XFER_COUNT_EN: xfer_cnt is constant 0, no counter flops; all other behaviour is identical.

Structure
REQ-034 Shared package bus_xfer_pkg: FSM state enum, default N_REG/ID_W constants, and the fixed FIFO depth of 2.
REQ-035 One sub-module: bus_xfer_fifo (2-entry FIFO of {src,dst}); the FSM, decode and counter live in the top module.

Verification
REQ-036 Single transfer src=2, dst=5 accepted at edge 0 -> reg_out=8'h04 in cycles 1-2; reg_in=8'h20 in cycle 2 only; done in cycle 3; xfer_cnt=1.
REQ-037 Three requests (1->3, 4->0, 6->7) held back-to-back -> req_ready drops after 2 accepted; transfers execute in order with done at cycles 3, 6, 9; xfer_cnt=3.
REQ-038 Invalid requests src=dst=4, then dst=9 with N_REG=8 -> err pulses once each; no strobes; FIFO stays empty; xfer_cnt unchanged.
REQ-039 rst asserted during LATCH of 0->1 -> next cycle all strobes 0, no done, FIFO empty, xfer_cnt=0.
REQ-040 Random traffic of 1000 requests with one-hot checks on every cycle -> no invariant violation from REQ-026; xfer_cnt equals the number of valid requests (or 0 when the macro is undefined).

Source files
------------

// File: rtl/bus_xfer_pkg.sv
// ============================================================================
// Module   : bus_xfer_pkg
// Brief    : Shared FSM state, default sizing and request check for bus_xfer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_xfer_pkg;

    localparam int c_n_reg_dflt = 8;
    localparam int c_id_w_dflt  = 3;
    localparam int c_fifo_depth = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_LATCH = 2'd2,
        S_DONE  = 2'd3
    } xfer_state_t;

    // A register cannot feed itself, and both ends must exist.
    function automatic logic id_pair_ok(input int src, input int dst, input int n_reg);
        return (src != dst) && (src < n_reg) && (dst < n_reg);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bus_xfer_ctrl_if.sv
// ============================================================================
// Module   : bus_xfer_ctrl_if
// Brief    : Request handshake and register strobe bundle for bus_xfer_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bus_xfer_ctrl_if
    import bus_xfer_pkg::*;
#(
    parameter int N_REG = c_n_reg_dflt,
    parameter int ID_W  = c_id_w_dflt
);

    logic              req_valid;
    logic              req_ready;
    logic [ID_W-1:0]   req_src;
    logic [ID_W-1:0]   req_dst;
    logic [N_REG-1:0]  reg_out;
    logic [N_REG-1:0]  reg_in;
    logic              busy;
    logic              done;
    logic              err;
    logic [15:0]       xfer_cnt;

    modport master (
        output req_valid, req_src, req_dst,
        input  req_ready, reg_out, reg_in, busy, done, err, xfer_cnt
    );

    modport slave (
        input  req_valid, req_src, req_dst,
        output req_ready, reg_out, reg_in, busy, done, err, xfer_cnt
    );

endinterface

`default_nettype wire

// File: rtl/bus_xfer_fifo.sv
// ============================================================================
// Module   : bus_xfer_fifo
// Brief    : Two-entry request FIFO holding {src,dst} pairs, registered flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_xfer_fifo
    import bus_xfer_pkg::*;
#(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic         o_empty,
    output logic         o_ready
);

    logic [W-1:0] r_mem [c_fifo_depth];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;
    logic         r_empty;
    logic         r_ready;
    logic         w_do_push;
    logic         w_do_pop;
    logic [1:0]   w_count_nxt;

    assign w_do_pop    = i_pop && (r_count != 2'd0);
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign w_do_push   = i_push && ((r_count != 2'(c_fifo_depth)) || w_do_pop);
    assign w_count_nxt = r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};

    assign o_data  = r_mem[r_rd_ptr];
    assign o_empty = r_empty;
    assign o_ready = r_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_empty  <= 1'b1;
            r_ready  <= 1'b1;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == 2'd0);
            r_ready <= (w_count_nxt != 2'(c_fifo_depth));
        end
    end

endmodule

`default_nettype wire

// File: rtl/bus_xfer_ctrl.sv
// ============================================================================
// Module   : bus_xfer_ctrl
// Brief    : Sequences register-to-register bus transfers as DRIVE/LATCH/DONE.
// Options  : BUS_XFER_COUNT_EN adds the saturating completed-transfer counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_xfer_ctrl
    import bus_xfer_pkg::*;
#(
    parameter int N_REG = c_n_reg_dflt,
    parameter int ID_W  = c_id_w_dflt
) (
    input  logic           clk,
    input  logic           rst,
    bus_xfer_ctrl_if.slave bus
);

    localparam logic [N_REG-1:0] c_one = N_REG'(1);

    xfer_state_t       r_state;
    logic [ID_W-1:0]   r_dst;
    logic [N_REG-1:0]  r_reg_out;
    logic [N_REG-1:0]  r_reg_in;
    logic              r_done;
    logic              r_err;
    logic              r_busy;

    logic              w_req_ok;
    logic              w_accept;
    logic              w_push;
    logic              w_take;
    logic              w_busy_nxt;
    logic              w_fifo_empty;
    logic              w_fifo_ready;
    logic [ID_W-1:0]   w_head_src;
    logic [ID_W-1:0]   w_head_dst;

    assign w_req_ok = id_pair_ok(int'(bus.req_src), int'(bus.req_dst), N_REG);
    assign w_accept = bus.req_valid && w_fifo_ready;
    assign w_push   = w_accept && w_req_ok;
    assign w_take   = ((r_state == S_IDLE) || (r_state == S_DONE)) && !w_fifo_empty;
    // Next-cycle busy: mid-transfer, or something queued after this edge.
    assign w_busy_nxt = (r_state == S_DRIVE) || (r_state == S_LATCH) || !w_fifo_empty || w_push;

    bus_xfer_fifo #(
        .W (2 * ID_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_take),
        .i_data  ({bus.req_src, bus.req_dst}),
        .o_data  ({w_head_src, w_head_dst}),
        .o_empty (w_fifo_empty),
        .o_ready (w_fifo_ready)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_dst     <= '0;
            r_reg_out <= '0;
            r_reg_in  <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_err  <= w_accept && !w_req_ok;
            r_done <= 1'b0;
            r_busy <= w_busy_nxt;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_take) begin
                        r_state   <= S_DRIVE;
                        r_dst     <= w_head_dst;
                        r_reg_out <= c_one << w_head_src;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_DRIVE: begin
                    r_state  <= S_LATCH;
                    r_reg_in <= c_one << r_dst;
                end
                S_LATCH: begin
                    r_state   <= S_DONE;
                    r_reg_out <= '0;
                    r_reg_in  <= '0;
                    r_done    <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef BUS_XFER_COUNT_EN
    logic [15:0] r_xfer_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_xfer_cnt <= 16'h0000;
        end else if ((r_state == S_LATCH) && (r_xfer_cnt != 16'hFFFF)) begin
            r_xfer_cnt <= r_xfer_cnt + 16'd1;
        end
    end

    assign bus.xfer_cnt = r_xfer_cnt;
`else
    assign bus.xfer_cnt = 16'h0000;
`endif

    assign bus.req_ready = w_fifo_ready;
    assign bus.reg_out   = r_reg_out;
    assign bus.reg_in    = r_reg_in;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_bus_xfer_ctrl.sv
// ============================================================================
// Module   : tb_bus_xfer_ctrl
// Brief    : Scoreboard bench for bus_xfer_ctrl (follows BUS_XFER_COUNT_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_xfer_ctrl;

    localparam int N_REG = 8;
    // One spare ID bit so out-of-range IDs such as 9 can be presented.
    localparam int ID_W  = 4;
`ifdef BUS_XFER_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         acc_cyc = 0;
    int         exp_cnt = 0;
    int         n_valid = 0;
    int         t0 = 0;
    logic       err_exp = 1'b0;
    logic       done_exp = 1'b0;
    logic [7:0] mon_e;
    logic [7:0] exp_q [$];
    int         done_log [$];

    bus_xfer_ctrl_if #(.N_REG(N_REG), .ID_W(ID_W)) bus ();

    bus_xfer_ctrl #(
        .N_REG (N_REG),
        .ID_W  (ID_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic bit req_ok(input int s, input int d);
        return (s != d) && (s < N_REG) && (d < N_REG);
    endfunction

    function automatic logic [31:0] cnt_exp(input int n);
        return CNT_EN ? 32'(n) : 32'd0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold the request until accepted; ready is stable between edges.
    task automatic send(input int s, input int d);
        logic acc;
        int   guard;
        guard = 0;
        bus.req_valid = 1'b1;
        bus.req_src   = 4'(s);
        bus.req_dst   = 4'(d);
        do begin
            acc = bus.req_ready;
            step();
            guard++;
        end while (!acc && guard < 50);
        bus.req_valid = 1'b0;
        if (!acc) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            acc_cyc = cyc;
            if (req_ok(s, d)) begin
                exp_q.push_back({4'(s), 4'(d)});
                n_valid++;
            end else begin
                err_exp = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_src   = 4'd1;
        bus.req_dst   = 4'd2;
        exp_q.delete();
        exp_cnt = 0;
        step();
        step();
        rst           = 1'b0;
        bus.req_valid = 1'b0;
        check("rst_out",   32'(bus.reg_out),   32'd0);
        check("rst_in",    32'(bus.reg_in),    32'd0);
        check("rst_done",  32'(bus.done),      32'd0);
        check("rst_err",   32'(bus.err),       32'd0);
        check("rst_busy",  32'(bus.busy),      32'd0);
        check("rst_ready", 32'(bus.req_ready), 32'd1);
        check("rst_cnt",   32'(bus.xfer_cnt),  32'd0);
        step();
        check("rst_req_ignored", 32'(bus.busy), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            err_exp  = 1'b0;
            done_exp = 1'b0;
        end else begin
            check("err", 32'(bus.err), 32'(err_exp));
            err_exp = 1'b0;
            check("done", 32'(bus.done), 32'(done_exp));
            if (bus.done) begin
                done_log.push_back(cyc);
                check("xfer_cnt", 32'(bus.xfer_cnt), cnt_exp(exp_cnt));
            end
            check("out_onehot", 32'($countones(bus.reg_out) <= 1), 32'd1);
            check("in_onehot",  32'($countones(bus.reg_in) <= 1),  32'd1);
            check("in_out_overlap", 32'(bus.reg_in & bus.reg_out), 32'd0);
            if (bus.reg_in != '0) begin
                if (exp_q.size() == 0) begin
                    check("spurious_latch", 32'(bus.reg_in), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("latch_src", 32'(bus.reg_out), 32'd1 << mon_e[7:4]);
                    check("latch_dst", 32'(bus.reg_in),  32'd1 << mon_e[3:0]);
                    exp_cnt++;
                end
            end
            done_exp = (bus.reg_in != '0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_src   = '0;
        bus.req_dst   = '0;
        #1;
        do_reset();

        // Single transfer 2 -> 5, cycle-exact.
        send(2, 5);
        check("t1_c0_out",  32'(bus.reg_out), 32'h00);
        check("t1_c0_busy", 32'(bus.busy),    32'd1);
        step();
        check("t1_c1_out", 32'(bus.reg_out), 32'h04);
        check("t1_c1_in",  32'(bus.reg_in),  32'h00);
        step();
        check("t1_c2_out", 32'(bus.reg_out), 32'h04);
        check("t1_c2_in",  32'(bus.reg_in),  32'h20);
        step();
        check("t1_c3_out",  32'(bus.reg_out),  32'h00);
        check("t1_c3_in",   32'(bus.reg_in),   32'h00);
        check("t1_c3_done", 32'(bus.done),     32'd1);
        check("t1_c3_cnt",  32'(bus.xfer_cnt), cnt_exp(1));
        step();
        check("t1_c4_done", 32'(bus.done), 32'd0);
        check("t1_c4_busy", 32'(bus.busy), 32'd0);

        // Three back-to-back requests.
        done_log.delete();
        send(1, 3);
        t0 = acc_cyc;
        send(4, 0);
        check("b2b_acc2", 32'(acc_cyc - t0), 32'd1);
        send(6, 7);
        check("b2b_acc3",      32'(acc_cyc - t0),   32'd2);
        check("b2b_ready_low", 32'(bus.req_ready),  32'd0);
        repeat (10) step();
        check("b2b_ndone", 32'(done_log.size()), 32'd3);
        for (int i = 0; i < 3 && i < done_log.size(); i++) begin
            check("b2b_done_cyc", 32'(done_log[i] - t0), 32'(3 * (i + 1)));
        end
        check("b2b_cnt",  32'(bus.xfer_cnt), cnt_exp(4));
        check("b2b_busy", 32'(bus.busy),     32'd0);

        // Rejected requests.
        send(4, 4);
        check("inv1_err",   32'(bus.err),       32'd1);
        check("inv1_busy",  32'(bus.busy),      32'd0);
        check("inv1_ready", 32'(bus.req_ready), 32'd1);
        step();
        check("inv1_err_off", 32'(bus.err), 32'd0);
        send(1, 9);
        check("inv2_err", 32'(bus.err), 32'd1);
        step();
        check("inv2_err_off", 32'(bus.err),      32'd0);
        check("inv2_busy",    32'(bus.busy),     32'd0);
        check("inv2_out",     32'(bus.reg_out),  32'd0);
        check("inv2_cnt",     32'(bus.xfer_cnt), cnt_exp(4));

        // Reset during LATCH of 0 -> 1.
        send(0, 1);
        step();
        step();
        check("rl_latch_in", 32'(bus.reg_in), 32'h02);
        rst = 1'b1;
        exp_q.delete();
        step();
        check("rl_out",   32'(bus.reg_out),   32'd0);
        check("rl_in",    32'(bus.reg_in),    32'd0);
        check("rl_done",  32'(bus.done),      32'd0);
        check("rl_busy",  32'(bus.busy),      32'd0);
        check("rl_ready", 32'(bus.req_ready), 32'd1);
        check("rl_cnt",   32'(bus.xfer_cnt),  32'd0);
        rst = 1'b0;
        exp_cnt = 0;
        step();
        check("rl_after_done", 32'(bus.done), 32'd0);
        check("rl_after_busy", 32'(bus.busy), 32'd0);

        // Random traffic.
        n_valid = 0;
        for (int i = 0; i < 1000; i++) begin
            int s;
            int d;
            s = int'($urandom_range(0, 9));
            d = int'($urandom_range(0, 9));
            if ($urandom_range(0, 3) == 0) step();
            send(s, d);
        end
        for (int i = 0; i < 40 && bus.busy; i++) step();
        step();
        check("rand_drain_busy", 32'(bus.busy),     32'd0);
        check("rand_drain_q",    32'(exp_q.size()), 32'd0);
        check("rand_cnt",        32'(bus.xfer_cnt), cnt_exp(n_valid));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
